// File: rtl/alu_instr_encoder.sv
// ALU-op to LC-3b instruction encoder with an output FIFO; word visible one cycle after accept.
// Define ALU_ENC_ILLEGAL_NOP_EN to enqueue 16'h0000 for illegal requests instead of dropping them.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [3:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra,
    alu_sub, alu_or, alu_nor, alu_nand, alu_xor, alu_xnor
  } lc3b_aluop;
endpackage

module alu_instr_encoder
  import lc3b_types::*;
#(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  lc3b_aluop                req_aluop,
  input  logic [2:0]               req_dr,
  input  logic [2:0]               req_sr1,
  input  logic [2:0]               req_sr2,
  input  logic [4:0]               req_imm,
  input  logic                     req_use_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output lc3b_word                 out_instr,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_pulse,
  output logic [ERRW-1:0]          err_count
);

  localparam int AW = $clog2(DEPTH);

  lc3b_word        mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  lc3b_word        enc, wr_word;
  logic            legal, accept, push, pop;

  always_comb begin
    enc   = {4'b0000, req_dr, req_sr1, 6'b000000};
    legal = 1'b1;
    case (req_aluop)
      alu_add:  enc[15:0] = req_use_imm ? {4'b0001, req_dr, req_sr1, 1'b1, req_imm}
                                        : {4'b0001, req_dr, req_sr1, 3'b000, req_sr2};
      alu_and:  enc[15:0] = req_use_imm ? {4'b0101, req_dr, req_sr1, 1'b1, req_imm}
                                        : {4'b0101, req_dr, req_sr1, 3'b000, req_sr2};
      alu_sub:  begin enc = {4'b0001, req_dr, req_sr1, 3'b001, req_sr2}; legal = !req_use_imm; end
      alu_or:   begin enc = {4'b0001, req_dr, req_sr1, 3'b010, req_sr2}; legal = !req_use_imm; end
      alu_nor:  begin enc = {4'b0001, req_dr, req_sr1, 3'b011, req_sr2}; legal = !req_use_imm; end
      alu_nand: begin enc = {4'b0101, req_dr, req_sr1, 3'b001, req_sr2}; legal = !req_use_imm; end
      alu_xor:  begin enc = {4'b0101, req_dr, req_sr1, 3'b010, req_sr2}; legal = !req_use_imm; end
      alu_xnor: begin enc = {4'b0101, req_dr, req_sr1, 3'b011, req_sr2}; legal = !req_use_imm; end
      alu_not:  enc = {4'b1001, req_dr, req_sr1, 6'b111111};
      // Shifts carry imm4 only; bit 4 of the immediate is dropped.
      alu_sll:  begin enc = {4'b1101, req_dr, req_sr1, 2'b00, req_imm[3:0]}; legal = req_use_imm; end
      alu_srl:  begin enc = {4'b1101, req_dr, req_sr1, 2'b01, req_imm[3:0]}; legal = req_use_imm; end
      alu_sra:  begin enc = {4'b1101, req_dr, req_sr1, 2'b11, req_imm[3:0]}; legal = req_use_imm; end
      default:  legal = 1'b0;
    endcase
  end

  assign req_ready = (occupancy != (AW+1)'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;
  assign out_instr = mem[rptr];

`ifdef ALU_ENC_ILLEGAL_NOP_EN
  assign push    = accept;
  assign wr_word = legal ? enc : 16'h0000;
`else
  assign push    = accept && legal;
  assign wr_word = enc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_word;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
      err_pulse <= accept && !legal;
      if (accept && !legal && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed bench for alu_instr_encoder: encoding table, ordering, backpressure, illegal requests, reset.
module tb_alu_instr_encoder;
  import lc3b_types::*;

  localparam int DEPTH = 4;
  localparam int ERRW  = 8;
`ifdef ALU_ENC_ILLEGAL_NOP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  logic                  clk, rst;
  logic                  req_valid, req_ready;
  lc3b_aluop             req_aluop;
  logic [2:0]            req_dr, req_sr1, req_sr2;
  logic [4:0]            req_imm;
  logic                  req_use_imm;
  logic                  out_valid, out_ready;
  lc3b_word              out_instr;
  logic [$clog2(DEPTH):0] occupancy;
  logic                  err_pulse;
  logic [ERRW-1:0]       err_count;

  alu_instr_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
    .req_dr(req_dr), .req_sr1(req_sr1), .req_sr2(req_sr2), .req_imm(req_imm),
    .req_use_imm(req_use_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .occupancy(occupancy), .err_pulse(err_pulse), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    lc3b_aluop  op;
    logic [2:0] dr, sr1, sr2;
    logic [4:0] imm;
    logic       use_imm;
    logic       legal;
    logic [15:0] word;
  } vec_t;

  vec_t        vecs [18];
  logic [15:0] q [$];
  int          checks = 0;
  int          failures = 0;
  int          err_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_aluop = v.op; req_dr = v.dr; req_sr1 = v.sr1; req_sr2 = v.sr2;
    req_imm = v.imm; req_use_imm = v.use_imm;
  endtask

  function automatic vec_t mk(lc3b_aluop op, logic [2:0] dr, logic [2:0] sr1, logic [2:0] sr2,
                              logic [4:0] imm, logic use_imm, logic legal, logic [15:0] word);
    vec_t v;
    v.op = op; v.dr = dr; v.sr1 = sr1; v.sr2 = sr2; v.imm = imm;
    v.use_imm = use_imm; v.legal = legal; v.word = word;
    return v;
  endfunction

  // One clock of ADD-register traffic (word 16'h1280|idx) against a queue model.
  task automatic step(input logic v, input logic [2:0] idx, input logic rdy);
    logic acc, pp;
    drive(mk(alu_add, 3'd1, 3'd2, idx, 5'd0, 1'b0, 1'b1, 16'h0));
    req_valid = v;
    out_ready = rdy;
    check("step_req_ready", {31'b0, req_ready}, {31'b0, q.size() != DEPTH});
    acc = v && (q.size() != DEPTH);
    pp  = rdy && (q.size() > 0);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(16'h1280 | {13'b0, idx});
    @(negedge clk);
    check("step_occupancy", 32'(occupancy), 32'(q.size()));
    check("step_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) check("step_out_instr", 32'(out_instr), 32'(q[0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(alu_add,  3'd1, 3'd2, 3'd3, 5'h00, 1'b0, 1'b1, 16'h1283);
    vecs[1]  = mk(alu_add,  3'd1, 3'd2, 3'd0, 5'h1F, 1'b1, 1'b1, 16'h12BF);
    vecs[2]  = mk(alu_not,  3'd4, 3'd5, 3'd0, 5'h00, 1'b0, 1'b1, 16'h997F);
    vecs[3]  = mk(alu_sra,  3'd0, 3'd7, 3'd0, 5'h03, 1'b1, 1'b1, 16'hD1F3);
    vecs[4]  = mk(alu_xnor, 3'd6, 3'd6, 3'd1, 5'h00, 1'b0, 1'b1, 16'h5D99);
    vecs[5]  = mk(alu_and,  3'd3, 3'd4, 3'd0, 5'h10, 1'b1, 1'b1, 16'h5730);
    vecs[6]  = mk(alu_sll,  3'd2, 3'd3, 3'd0, 5'h1A, 1'b1, 1'b1, 16'hD4CA);
    vecs[7]  = mk(alu_srl,  3'd5, 3'd1, 3'd0, 5'h0F, 1'b1, 1'b1, 16'hDA5F);
    vecs[8]  = mk(alu_or,   3'd7, 3'd0, 3'd5, 5'h00, 1'b0, 1'b1, 16'h1E15);
    vecs[9]  = mk(alu_nand, 3'd0, 3'd1, 3'd2, 5'h00, 1'b0, 1'b1, 16'h504A);
    vecs[10] = mk(alu_nor,  3'd1, 3'd1, 3'd7, 5'h00, 1'b0, 1'b1, 16'h125F);
    vecs[11] = mk(alu_xor,  3'd2, 3'd3, 3'd4, 5'h00, 1'b0, 1'b1, 16'h54D4);
    vecs[12] = mk(alu_sub,  3'd4, 3'd4, 3'd4, 5'h00, 1'b0, 1'b1, 16'h190C);
    vecs[13] = mk(alu_not,  3'd0, 3'd0, 3'd0, 5'h15, 1'b1, 1'b1, 16'h903F);
    vecs[14] = mk(alu_sub,  3'd1, 3'd1, 3'd1, 5'h01, 1'b1, 1'b0, 16'h0000);
    vecs[15] = mk(alu_pass, 3'd1, 3'd1, 3'd1, 5'h01, 1'b0, 1'b0, 16'h0000);
    vecs[16] = mk(alu_sll,  3'd1, 3'd1, 3'd0, 5'h02, 1'b0, 1'b0, 16'h0000);
    vecs[17] = mk(alu_xor,  3'd1, 3'd1, 3'd0, 5'h02, 1'b1, 1'b0, 16'h0000);

    rst = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    #3;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'h0000);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_err_pulse", {31'b0, err_pulse}, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Table: one request, check one cycle later, then pop it.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      if (!vecs[i].legal) err_exp++;
      check("tbl_out_valid", {31'b0, out_valid}, {31'b0, vecs[i].legal || NOP_EN});
      if (vecs[i].legal || NOP_EN) check("tbl_out_instr", 32'(out_instr), 32'(vecs[i].word));
      check("tbl_err_pulse", {31'b0, err_pulse}, {31'b0, !vecs[i].legal});
      check("tbl_err_count", 32'(err_count), 32'(err_exp));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("tbl_drained", 32'(occupancy), 32'd0);
      check("tbl_err_pulse_clr", {31'b0, err_pulse}, 32'd0);
    end

    // Back-to-back ADD imm then NOT, drained in order.
    drive(vecs[1]); req_valid = 1'b1;
    @(negedge clk);
    drive(vecs[2]);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_occupancy", 32'(occupancy), 32'd2);
    check("b2b_head0", 32'(out_instr), 32'h12BF);
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_head1", 32'(out_instr), 32'h997F);
    check("b2b_valid1", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_empty", {31'b0, out_valid}, 32'd0);

    // Two consecutive illegal requests.
    drive(vecs[14]); req_valid = 1'b1;
    @(negedge clk);
    drive(vecs[15]);
    check("ill_pulse0", {31'b0, err_pulse}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    err_exp += 2;
    check("ill_pulse1", {31'b0, err_pulse}, 32'd1);
    check("ill_count", 32'(err_count), 32'(err_exp));
    check("ill_occupancy", 32'(occupancy), NOP_EN ? 32'd2 : 32'd0);
    if (NOP_EN) check("ill_nop_word", 32'(out_instr), 32'h0000);
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("ill_drained", 32'(occupancy), 32'd0);

    // Fill, stall, then streaming push+pop, then drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 1'b0);
    check("full_occupancy", 32'(occupancy), 32'(DEPTH));
    check("full_req_ready", {31'b0, req_ready}, 32'd0);
    step(1'b1, 3'd4, 1'b0);
    for (int i = 4; i < 8; i++) step(1'b1, 3'(i), 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 3'd0, 1'b1);
    check("stream_empty", 32'(occupancy), 32'd0);

    // Asynchronous reset with 3 entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 3'(i), 1'b0);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_occupancy", 32'(occupancy), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    err_exp = 0;
    step(1'b1, 3'd5, 1'b0);
    check("post_rst_instr", 32'(out_instr), 32'h1285);
    step(1'b0, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
